// File: rtl/vlb_pkg.sv
// Shared frame-buffer pixel format: type/colour constants, draw-colour and
// packer state enums, and the RGB565 + overlay -> 8-bit encoder.
package vlb_pkg;

    localparam logic [1:0] PIX_TYPE_DRAWN = 2'b11;
    localparam logic [1:0] PIX_TYPE_CAM   = 2'b00;

    localparam logic [5:0] COLOR_MAGENTA = 6'b111111;
    localparam logic [5:0] COLOR_YELLOW  = 6'b101010;
    localparam logic [5:0] COLOR_BLUE    = 6'b000000;

    typedef enum logic [1:0] {
        MAGENTA = 2'd0,
        YELLOW  = 2'd1,
        BLUE    = 2'd2,
        ERASE   = 2'd3
    } draw_color_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Erase falls through to the camera pixel, exactly like an undrawn pixel.
    function automatic logic [7:0] pack_pixel(input logic [15:0] rgb565,
                                              input logic draw,
                                              input draw_color_e color);
        logic [7:0] p;
        p = {PIX_TYPE_CAM, rgb565[15:14], rgb565[10:9], rgb565[4:3]};
        if (draw) begin
            case (color)
                MAGENTA: p = {PIX_TYPE_DRAWN, COLOR_MAGENTA};
                YELLOW:  p = {PIX_TYPE_DRAWN, COLOR_YELLOW};
                BLUE:    p = {PIX_TYPE_DRAWN, COLOR_BLUE};
                default: ;
            endcase
        end
        return p;
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// Decimates the camera/overlay pixel stream and writes packed bytes to the
// frame-buffer BRAM with a sequential address counter.
module pixel_packer
    import vlb_pkg::*;
#(
    parameter int IN_WIDTH   = 320,
    parameter int IN_HEIGHT  = 240,
    parameter int DECIM_LOG2 = 1,
    parameter int ADDR_W     = $clog2((IN_WIDTH >> DECIM_LOG2) * (IN_HEIGHT >> DECIM_LOG2))
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              valid_in,
    input  logic              frame_start_in,
    input  logic [15:0]       pixel_in,
    input  logic              draw_in,
    input  logic [1:0]        draw_color_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [7:0]        data_out,
    output logic              we_out,
    output logic              frame_done_out,
    output logic [1:0]        err_out
);

    localparam int COL_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IN_HEIGHT - 1);
    localparam logic [COL_W-1:0] DEC_MASK_C = COL_W'((1 << DECIM_LOG2) - 1);
    localparam logic [ROW_W-1:0] DEC_MASK_R = ROW_W'((1 << DECIM_LOG2) - 1);

    // Accepted-pixel register: the edge that samples valid_in.
    logic        in_valid, in_start, in_draw;
    logic [15:0] in_pixel;
    logic [1:0]  in_color;

    state_e             state, nxt_state;
    logic [COL_W-1:0]   col, nxt_col, pc;
    logic [ROW_W-1:0]   row, nxt_row, pr;
    logic [ADDR_W-1:0]  addr, nxt_addr, pa;
    logic               proc, kept, last, err_short, err_over;

    logic               s1_we, s1_done;
    logic [ADDR_W-1:0]  s1_addr;
    logic [7:0]         s1_data;
    logic [1:0]         s1_err;

    always_comb begin
        nxt_state = state;
        nxt_col   = col;
        nxt_row   = row;
        nxt_addr  = addr;
        proc      = 1'b0;
        pc        = col;
        pr        = row;
        pa        = addr;
        err_short = 1'b0;
        err_over  = 1'b0;
        if (in_valid) begin
            if (in_start) begin
                proc      = 1'b1;
                pc        = '0;
                pr        = '0;
                pa        = '0;
                err_short = (state == ACTIVE) && ((col != '0) || (row != '0));
            end else if (state == ACTIVE) begin
                proc = 1'b1;
            end else if (state == DONE) begin
                err_over = 1'b1;
            end
        end
        kept = proc && ((pc & DEC_MASK_C) == '0) && ((pr & DEC_MASK_R) == '0);
        last = proc && (pc == COL_LAST) && (pr == ROW_LAST);
        if (proc) begin
            nxt_addr = kept ? pa + 1'b1 : pa;
            if (pc == COL_LAST) begin
                nxt_col = '0;
                nxt_row = (pr == ROW_LAST) ? '0 : pr + 1'b1;
            end else begin
                nxt_col = pc + 1'b1;
                nxt_row = pr;
            end
            nxt_state = last ? DONE : ACTIVE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            in_valid       <= 1'b0;
            in_start       <= 1'b0;
            in_draw        <= 1'b0;
            in_pixel       <= '0;
            in_color       <= '0;
            state          <= IDLE;
            col            <= '0;
            row            <= '0;
            addr           <= '0;
            s1_we          <= 1'b0;
            s1_done        <= 1'b0;
            s1_addr        <= '0;
            s1_data        <= '0;
            s1_err         <= '0;
            we_out         <= 1'b0;
            frame_done_out <= 1'b0;
            addr_out       <= '0;
            data_out       <= '0;
            err_out        <= '0;
        end else begin
            in_valid <= valid_in;
            in_start <= valid_in & frame_start_in;
            in_draw  <= draw_in;
            in_pixel <= pixel_in;
            in_color <= draw_color_in;
            state    <= nxt_state;
            col      <= nxt_col;
            row      <= nxt_row;
            addr     <= nxt_addr;
            s1_we    <= kept;
            s1_done  <= last;
            s1_err   <= {err_over, err_short};
            if (kept) begin
                s1_addr <= pa;
                s1_data <= pack_pixel(in_pixel, in_draw, draw_color_e'(in_color));
            end
            we_out         <= s1_we;
            frame_done_out <= s1_done;
            err_out        <= s1_err;
            // Address and data hold between writes.
            if (s1_we) begin
                addr_out <= s1_addr;
                data_out <= s1_data;
            end
        end
    end

endmodule

// File: tb/tb_pixel_packer.sv
// Self-checking bench for pixel_packer on an 8x4 frame with 2x decimation.
module tb_pixel_packer;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int D   = 1;
    localparam int DEC = 1 << D;
    localparam int AW  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, valid, frame_start, draw;
    logic [15:0]   pixel;
    logic [1:0]    draw_color;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          we, frame_done;
    logic [1:0]    err;

    pixel_packer #(.IN_WIDTH(W), .IN_HEIGHT(H), .DECIM_LOG2(D), .ADDR_W(AW)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid), .frame_start_in(frame_start),
        .pixel_in(pixel), .draw_in(draw), .draw_color_in(draw_color),
        .addr_out(addr), .data_out(data), .we_out(we),
        .frame_done_out(frame_done), .err_out(err)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          done;
        logic [1:0]    err;
    } out_t;
    localparam int OUT_W = $bits(out_t);

    logic [OUT_W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    // Reference model: linear position inside the frame; 0 idle, 1 in frame, 2 frame complete.
    int            mode = 0;
    int            pos  = 0;
    logic [AW-1:0] hold_addr = '0;
    logic [7:0]    hold_data = '0;

    function automatic logic [7:0] ref_pack(input logic [15:0] p, input logic d, input logic [1:0] c);
        if (d && c == 2'd0) return 8'hFF;
        if (d && c == 2'd1) return 8'hEA;
        if (d && c == 2'd2) return 8'hC0;
        return {2'b00, p[15:14], p[10:9], p[4:3]};
    endfunction

    task automatic model_step(input logic r, input logic v, input logic fs,
                              input logic [15:0] p, input logic d, input logic [1:0] c);
        out_t e;
        int   cx, ry;
        bit   proc;
        if (!r) begin
            exp_q.delete();
            repeat (3) exp_q.push_back('0);
            mode = 0; pos = 0; hold_addr = '0; hold_data = '0;
            return;
        end
        e = '0;
        e.addr = hold_addr;
        e.data = hold_data;
        proc = 0;
        if (v) begin
            if (fs) begin
                if (mode == 1 && pos != 0) e.err[0] = 1'b1;
                mode = 1; pos = 0; proc = 1;
            end else if (mode == 1) begin
                proc = 1;
            end else if (mode == 2) begin
                e.err[1] = 1'b1;
            end
        end
        if (proc) begin
            cx = pos % W;
            ry = pos / W;
            if (cx % DEC == 0 && ry % DEC == 0) begin
                e.we   = 1'b1;
                e.addr = AW'((ry / DEC) * (W / DEC) + cx / DEC);
                e.data = ref_pack(p, d, c);
                hold_addr = e.addr;
                hold_data = e.data;
            end
            if (pos == W * H - 1) begin
                e.done = 1'b1;
                mode = 2;
            end else begin
                pos++;
            end
        end
        exp_q.push_back(e);
    endtask

    // Observes the outputs of the previous edge, then drives the next input.
    task automatic cycle(input logic r, input logic v, input logic fs, input logic [15:0] p,
                         input logic d, input logic [1:0] c, output out_t obs, output out_t exp);
        @(negedge clk);
        obs = '{we, addr, data, frame_done, err};
        exp = out_t'(exp_q.pop_front());
        rst_n = r; valid = v; frame_start = fs; pixel = p; draw = d; draw_color = c;
        model_step(r, v, fs, p, d, c);
    endtask

    task automatic test_reset();
        out_t obs, exp;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 16'($urandom), 1'b0, 2'd0, obs, exp);
            checks++;
            if (obs !== exp || obs !== out_t'('0)) begin
                errors++;
                $display("FAIL test_reset cyc%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_single_frame();
        out_t obs, exp;
        int nwr = 0, ndone = 0;
        for (int i = 0; i < W * H + 4; i++) begin
            if (i < W * H) cycle(1'b1, 1'b1, i == 0, 16'hFFFF, 1'b0, 2'd0, obs, exp);
            else           cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL test_single_frame cyc%0d got=%h want=%h", i, obs, exp);
            end
            if (obs.we === 1'b1) begin
                checks++;
                if (obs.addr !== AW'(nwr) || obs.data !== 8'h3F) begin
                    errors++;
                    $display("FAIL test_single_frame write%0d got addr=%0d data=%h want addr=%0d data=3f",
                             nwr, obs.addr, obs.data, nwr);
                end
                nwr++;
            end
            if (obs.done === 1'b1) ndone++;
        end
        checks++;
        if (nwr != 8 || ndone != 1) begin
            errors++;
            $display("FAIL test_single_frame counts got writes=%0d done=%0d want 8/1", nwr, ndone);
        end
    endtask

    task automatic test_draw_colors();
        out_t obs, exp;
        logic [7:0] want[4];
        int nwr = 0;
        want[0] = 8'hFF; want[1] = 8'hEA; want[2] = 8'hC0; want[3] = 8'h30;
        for (int i = 0; i < W * H + 4; i++) begin
            if (i < W * H)
                cycle(1'b1, 1'b1, i == 0, 16'hF800, (i < 8) && (i % 2 == 0), 2'(i / 2), obs, exp);
            else
                cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL test_draw_colors cyc%0d got=%h want=%h", i, obs, exp);
            end
            if (obs.we === 1'b1 && nwr < 4) begin
                checks++;
                if (obs.data !== want[nwr]) begin
                    errors++;
                    $display("FAIL test_draw_colors colour%0d got=%h want=%h", nwr, obs.data, want[nwr]);
                end
                nwr++;
            end
        end
    endtask

    task automatic test_random_frames();
        out_t obs, exp;
        int sent = 0, i = 0;
        while (sent < 2 * W * H) begin
            if ($urandom_range(0, 3) != 0) begin
                cycle(1'b1, 1'b1, (sent % (W * H)) == 0, 16'($urandom), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), obs, exp);
                sent++;
            end else begin
                cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 2'd0, obs, exp);
            end
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL test_random_frames cyc%0d got=%h want=%h", i, obs, exp);
            end
            i++;
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'd0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL test_random_frames drain%0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_short_frame();
        out_t obs, exp;
        int nerr0 = 0, ndone = 0;
        // Restart at pixel (5,1), i.e. linear position 13 of the aborted frame.
        for (int i = 0; i < 13 + W * H + 4; i++) begin
            if (i < 13 + W * H)
                cycle(1'b1, 1'b1, i == 0 || i == 13, 16'($urandom), 1'b0, 2'd0, obs, exp);
            else
                cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'd0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL test_short_frame cyc%0d got=%h want=%h", i, obs, exp);
            end
            if (obs.err[0] === 1'b1) begin
                nerr0++;
                checks++;
                if (obs.we !== 1'b1 || obs.addr !== '0 || ndone != 0) begin
                    errors++;
                    $display("FAIL test_short_frame restart got we=%b addr=%0d done=%0d want 1/0/0",
                             obs.we, obs.addr, ndone);
                end
            end
            if (obs.done === 1'b1) ndone++;
        end
        checks++;
        if (nerr0 != 1 || ndone != 1) begin
            errors++;
            $display("FAIL test_short_frame counts got err0=%0d done=%0d want 1/1", nerr0, ndone);
        end
    endtask

    task automatic test_overrun();
        out_t obs, exp;
        int nerr1 = 0, first_addr = -1;
        for (int i = 0; i < W * H + 3 + 1 + 4; i++) begin
            if (i < W * H + 3)
                cycle(1'b1, 1'b1, i == 0, 16'($urandom), 1'b0, 2'd0, obs, exp);
            else if (i == W * H + 3)
                cycle(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 2'd0, obs, exp);
            else
                cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'd0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL test_overrun cyc%0d got=%h want=%h", i, obs, exp);
            end
            if (obs.err[1] === 1'b1) begin
                nerr1++;
                checks++;
                if (obs.we !== 1'b0) begin
                    errors++;
                    $display("FAIL test_overrun write during overrun got we=%b want 0", obs.we);
                end
            end else if (nerr1 == 3 && obs.we === 1'b1 && first_addr < 0) begin
                first_addr = int'(obs.addr);
            end
        end
        checks++;
        if (nerr1 != 3 || first_addr != 0) begin
            errors++;
            $display("FAIL test_overrun counts got err1=%0d restart_addr=%0d want 3/0", nerr1, first_addr);
        end
    endtask

    task automatic test_mid_reset();
        out_t obs, exp;
        int bad = 0;
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'b1, i == 0, 16'($urandom), 1'b0, 2'd0, obs, exp);
        cycle(1'b0, 1'b1, 1'b0, 16'($urandom), 1'b0, 2'd0, obs, exp);
        for (int i = 0; i < 12; i++) begin
            if (i < 8) cycle(1'b1, 1'b1, 1'b0, 16'($urandom), 1'b0, 2'd0, obs, exp);
            else       cycle(1'b1, 1'b1, i == 8, 16'hFFFF, 1'b0, 2'd0, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL test_mid_reset cyc%0d got=%h want=%h", i, obs, exp);
            end
            if (i == 0) begin
                checks++;
                if (obs !== out_t'('0)) begin
                    errors++;
                    $display("FAIL test_mid_reset outputs after reset got=%h want=0", obs);
                end
            end
            if (i < 11 && (obs.we === 1'b1 || obs.err !== 2'b00)) bad++;
            if (i == 11) begin
                checks++;
                if (bad != 0 || obs.we !== 1'b1 || obs.addr !== '0) begin
                    errors++;
                    $display("FAIL test_mid_reset restart got bad=%0d we=%b addr=%0d want 0/1/0",
                             bad, obs.we, obs.addr);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; frame_start = 1'b0; pixel = '0; draw = 1'b0; draw_color = '0;
        repeat (3) exp_q.push_back('0);
        test_reset();
        test_single_frame();
        test_draw_colors();
        test_random_frames();
        test_short_frame();
        test_overrun();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
